// File: rtl/cdb_pkg.sv
// Shared CDB payload definition and bus geometry for the writeback arbiter.
`ifndef WAYS
`define WAYS 3
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PRF
`define PRF 64
`endif
`ifndef ROB
`define ROB 32
`endif

package cdb_pkg;

    localparam int unsigned XLEN_W    = `XLEN;
    localparam int unsigned PRF_IDX_W = $clog2(`PRF);
    localparam int unsigned ROB_IDX_W = $clog2(`ROB);

    typedef struct packed {
        logic [XLEN_W-1:0]    data;
        logic [PRF_IDX_W-1:0] prf_idx;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 direction;
        logic [XLEN_W-1:0]    target;
        logic                 reg_write;
    } cdb_packet_t;

    localparam cdb_packet_t CDB_PKT_ZERO = '0;

endpackage

// File: rtl/cdb_src_queue.sv
// Per-source circular result FIFO; flush and reset both drop every entry.
module cdb_src_queue
    import cdb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_push,
    input  cdb_packet_t i_pkt,
    input  logic        i_pop,
    output cdb_packet_t o_head,
    output logic        o_full,
    output logic        o_empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    cdb_packet_t   r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Index advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= f_next(r_tail);
            if (w_pop)  r_head <= f_next(r_head);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: the pointers define what is live.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_tail] <= i_pkt;
    end

    assign o_head  = r_mem[r_head];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Buffered rotating-priority arbiter placing up to NUM_CDB queued results per cycle on the CDB.
`ifndef WAYS
`define WAYS 3
`endif

module cdb_rr_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned NUM_SRC = `WAYS + 1,
    parameter int unsigned NUM_CDB = `WAYS,
    parameter int unsigned QDEPTH  = 2,
    parameter int unsigned IDXW    = $clog2(NUM_SRC)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic [NUM_SRC-1:0]  in_valid,
    input  cdb_packet_t         in_pkt [NUM_SRC],
    output logic [NUM_SRC-1:0]  in_ready,
    output logic [NUM_SRC-1:0]  gnt,
    output logic [NUM_CDB-1:0]  cdb_valid,
    output cdb_packet_t         cdb_pkt [NUM_CDB]
);

    localparam int unsigned RW = $clog2(NUM_SRC + 1);

    logic [IDXW-1:0]    r_ptr;
    logic [NUM_CDB-1:0] r_cdb_valid;
    cdb_packet_t        r_cdb_pkt [NUM_CDB];

    logic               w_live;
    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_empty;
    cdb_packet_t        w_head [NUM_SRC];
    logic [NUM_SRC-1:0] w_win;
    logic [NUM_CDB-1:0] w_lane_vld;
    logic [IDXW-1:0]    w_lane_src [NUM_CDB];
    logic [IDXW-1:0]    w_idx;
    logic [IDXW-1:0]    w_last;
    logic [IDXW-1:0]    w_ptr_nxt;
    logic [RW-1:0]      w_rank;

    assign w_live   = reset & ~flush;
    assign in_ready = ~w_full & {NUM_SRC{w_live}};
    assign gnt      = w_win & {NUM_SRC{w_live}};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_q
        cdb_src_queue #(
            .DEPTH (QDEPTH)
        ) u_q (
            .i_clk   (clock),
            .i_rst_n (reset),
            .i_flush (flush),
            .i_push  (in_valid[i] & in_ready[i]),
            .i_pkt   (in_pkt[i]),
            .i_pop   (gnt[i]),
            .o_head  (w_head[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i])
        );
    end

    // Scan from r_ptr; the n-th non-empty queue in scan order takes lane n.
    always_comb begin
        w_win      = '0;
        w_lane_vld = '0;
        w_last     = r_ptr;
        w_rank     = '0;
        w_idx      = '0;
        for (int unsigned l = 0; l < NUM_CDB; l++) w_lane_src[l] = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_idx = IDXW'((32'(r_ptr) + k) % NUM_SRC);
            if (!w_empty[w_idx]) begin
                if (w_rank < RW'(NUM_CDB)) begin
                    w_win[w_idx] = 1'b1;
                    w_last       = w_idx;
                    for (int unsigned l = 0; l < NUM_CDB; l++) begin
                        if (w_rank == RW'(l)) begin
                            w_lane_vld[l] = 1'b1;
                            w_lane_src[l] = w_idx;
                        end
                    end
                end
                w_rank = w_rank + RW'(1);
            end
        end
    end

    assign w_ptr_nxt = (w_last == IDXW'(NUM_SRC - 1)) ? '0 : w_last + IDXW'(1);

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            r_ptr       <= '0;
            r_cdb_valid <= '0;
            for (int unsigned l = 0; l < NUM_CDB; l++) r_cdb_pkt[l] <= CDB_PKT_ZERO;
        end else begin
            if (|w_win) r_ptr <= w_ptr_nxt;
            r_cdb_valid <= w_lane_vld;
            for (int unsigned l = 0; l < NUM_CDB; l++) begin
                r_cdb_pkt[l] <= w_lane_vld[l] ? w_head[w_lane_src[l]] : CDB_PKT_ZERO;
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_pkt   = r_cdb_pkt;

endmodule
